// File: rtl/finger_scan_if.sv
// finger_scan_if: palm-box handshake, mask read port and finger results of finger_scan_ctrl; zone_count exists with FINGER_ZONE_COUNT_EN
interface finger_scan_if #(
  parameter int ADDR_W = 15
);
  logic              box_valid;
  logic              box_ready;
  logic [7:0]        start_of_palm_r;
  logic [7:0]        start_of_palm_c;
  logic [7:0]        end_of_palm_r;
  logic [7:0]        end_of_palm_c;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_data;
  logic              thumb_status;
  logic              index_status;
  logic              middle_status;
  logic              ring_status;
  logic              pinky_status;
  logic              box_err;
  logic              result_valid;
`ifdef FINGER_ZONE_COUNT_EN
  logic [39:0]       zone_count;
`endif
  modport master (
    output box_valid, start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c, mem_rd_data,
    input  box_ready, mem_rd_en, mem_addr, thumb_status, index_status, middle_status,
    input  ring_status, pinky_status, box_err, result_valid
`ifdef FINGER_ZONE_COUNT_EN
    , input zone_count
`endif
  );
  modport slave (
    input  box_valid, start_of_palm_r, start_of_palm_c, end_of_palm_r, end_of_palm_c, mem_rd_data,
    output box_ready, mem_rd_en, mem_addr, thumb_status, index_status, middle_status,
    output ring_status, pinky_status, box_err, result_valid
`ifdef FINGER_ZONE_COUNT_EN
    , output zone_count
`endif
  );
endinterface

// File: rtl/finger_scan_ctrl.sv
// finger_scan_ctrl: scans the rows above a palm box, counts mask hits in five column zones, flags extended fingers; FINGER_ZONE_COUNT_EN exports the zone counts
module finger_scan_ctrl #(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 120,
  parameter int ADDR_W    = 15,
  parameter int SCAN_ROWS = 8,
  parameter int MIN_HITS  = 4
) (
  input logic          clk,
  input logic          rst,
  finger_scan_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DECIDE} state_t;
  localparam logic [7:0]        W8     = 8'(IMG_W);
  localparam logic [7:0]        H8     = 8'(IMG_H);
  localparam logic [7:0]        R8     = 8'(SCAN_ROWS);
  localparam logic [7:0]        M8     = 8'(MIN_HITS);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_W);
  state_t            state_q;
  logic [7:0]        sr_q, sc_q, ec_q, width_q, row_q, col_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [2:0]        zone_q, tag_q;
  logic [8:0]        acc_q;
  logic              rd_en_q, tag_v_q, err_q, box_err_q, rv_q;
  logic [4:0]        status_q;
  logic [7:0]        cnt_q [5];
`ifdef FINGER_ZONE_COUNT_EN
  logic [39:0]       zc_q;
`endif
  logic              bad, last_col, last_row, step;
  logic [7:0]        first_row;
  logic [ADDR_W-1:0] first_base;
  logic [8:0]        acc_d;
  // box checks, scan window start and divider-free zone stepping
  always_comb begin
    bad = bus.end_of_palm_c < bus.start_of_palm_c || bus.end_of_palm_r < bus.start_of_palm_r ||
          bus.end_of_palm_c >= W8 || bus.end_of_palm_r >= H8;
    first_row = sr_q >= R8 ? sr_q - R8 : 8'd0;
    first_base = ADDR_W'(first_row) * STRIDE;
    last_col = col_q == ec_q;
    last_row = row_q == sr_q - 8'd1;
    acc_d = acc_q + 9'd5;
    step = acc_d >= {1'b0, width_q};
  end
  // sequencer: accept box, issue one read per cycle, count tagged hits, register the verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      {sr_q, sc_q, ec_q, width_q, row_q, col_q} <= '0;
      {base_q, addr_q} <= '0;
      {zone_q, tag_q, acc_q} <= '0;
      {rd_en_q, tag_v_q, err_q, box_err_q, rv_q} <= '0;
      status_q <= '0;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
`ifdef FINGER_ZONE_COUNT_EN
      zc_q <= '0;
`endif
    end else begin
      rv_q <= 1'b0;
      tag_v_q <= rd_en_q;
      tag_q <= zone_q;
      for (int i = 0; i < 5; i++)
        if (tag_v_q && bus.mem_rd_data && tag_q == 3'(i) && cnt_q[i] != 8'hff) cnt_q[i] <= cnt_q[i] + 8'd1;
      case (state_q)
        IDLE: if (bus.box_valid) begin
          sr_q <= bus.start_of_palm_r;
          sc_q <= bus.start_of_palm_c;
          ec_q <= bus.end_of_palm_c;
          err_q <= bad;
          state_q <= bad ? DECIDE : SETUP;
        end
        SETUP: begin
          width_q <= ec_q - sc_q + 8'd1;
          row_q <= first_row;
          col_q <= sc_q;
          base_q <= first_base;
          addr_q <= first_base + ADDR_W'(sc_q);
          zone_q <= '0;
          acc_q <= '0;
          for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
          rd_en_q <= sr_q != 8'd0;
          state_q <= sr_q == 8'd0 ? DECIDE : SCAN;
        end
        SCAN: if (last_col && last_row) begin
          rd_en_q <= 1'b0;
          state_q <= DRAIN;
        end else if (last_col) begin
          row_q <= row_q + 8'd1;
          col_q <= sc_q;
          base_q <= base_q + STRIDE;
          addr_q <= base_q + STRIDE + ADDR_W'(sc_q);
          zone_q <= '0;
          acc_q <= '0;
        end else begin
          col_q <= col_q + 8'd1;
          addr_q <= addr_q + 1'b1;
          acc_q <= step ? acc_d - {1'b0, width_q} : acc_d;
          zone_q <= step && zone_q != 3'd4 ? zone_q + 3'd1 : zone_q;
        end
        DRAIN: state_q <= DECIDE;
        DECIDE: begin
          for (int i = 0; i < 5; i++) status_q[i] <= !err_q && cnt_q[i] >= M8;
`ifdef FINGER_ZONE_COUNT_EN
          for (int i = 0; i < 5; i++) zc_q[8*i +: 8] <= err_q ? 8'd0 : cnt_q[i];
`endif
          box_err_q <= err_q;
          rv_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.box_ready = rst && state_q == IDLE;
  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr = addr_q;
  assign bus.thumb_status = status_q[0];
  assign bus.index_status = status_q[1];
  assign bus.middle_status = status_q[2];
  assign bus.ring_status = status_q[3];
  assign bus.pinky_status = status_q[4];
  assign bus.box_err = box_err_q;
  assign bus.result_valid = rv_q;
`ifdef FINGER_ZONE_COUNT_EN
  assign bus.zone_count = zc_q;
`endif
endmodule

// File: tb/tb_finger_scan_ctrl.sv
// tb_finger_scan_ctrl: directed and randomized palm boxes against a pixel-level finger model
module tb_finger_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  finger_scan_if #(.ADDR_W(15)) bus();
  finger_scan_ctrl #(.IMG_W(160), .IMG_H(120), .ADDR_W(15), .SCAN_ROWS(8), .MIN_HITS(4)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  logic   mask [0:19199];
  int     n_vec = 0;
  int     n_err = 0;
  int     rd_n = 0;
  longint rd_sum = 0;
  int     rdq[$];
  int     rv_n = 0;
  // mask memory with one-cycle read latency plus read and result logging
  always @(posedge clk) begin
    bus.mem_rd_data <= bus.mem_rd_en ? mask[bus.mem_addr] : 1'b0;
    if (bus.mem_rd_en) begin
      rd_n++;
      rd_sum += longint'(bus.mem_addr);
      rdq.push_back(int'(bus.mem_addr));
    end
    if (bus.result_valid) rv_n++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask
  function automatic logic [4:0] statuses();
    return {bus.pinky_status, bus.ring_status, bus.middle_status, bus.index_status, bus.thumb_status};
  endfunction
  task automatic fill(input int density);
    for (int i = 0; i < 19200; i++) mask[i] = $urandom_range(0, 99) < density;
  endtask
  task automatic drive(input int sr, input int sc, input int er, input int ec);
    bus.start_of_palm_r = 8'(sr);
    bus.start_of_palm_c = 8'(sc);
    bus.end_of_palm_r = 8'(er);
    bus.end_of_palm_c = 8'(ec);
  endtask
  task automatic run_box(input int sr, input int sc, input int er, input int ec, input bit poke);
    int cnt[5];
    int w, fr, n, first, last, lat, rv0, rd0, g;
    longint sum, sum0;
    bit bad;
    logic [4:0] st;
    logic [39:0] zc;
    bad = ec < sc || er < sr || ec >= 160 || er >= 120;
    w = ec - sc + 1;
    fr = sr >= 8 ? sr - 8 : 0;
    n = 0;
    sum = 0;
    cnt = '{default: 0};
    if (!bad)
      for (int r = fr; r < sr; r++)
        for (int c = sc; c <= ec; c++) begin
          if (mask[r*160+c] && cnt[5*(c-sc)/w] < 255) cnt[5*(c-sc)/w]++;
          n++;
          sum += longint'(r*160 + c);
        end
    first = fr*160 + sc;
    last = (sr-1)*160 + ec;
    for (int z = 0; z < 5; z++) begin
      st[z] = !bad && cnt[z] >= 4;
      zc[8*z +: 8] = bad ? 8'd0 : 8'(cnt[z]);
    end
    @(negedge clk);
    bus.box_valid = 1'b1;
    drive(sr, sc, er, ec);
    g = 0;
    while (!bus.box_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("ready", bus.box_ready, 1);
    rd0 = rd_n;
    sum0 = rd_sum;
    rv0 = rv_n;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    if (poke) drive(0, 200, 0, 10);
    else bus.box_valid = 1'b0;
    while (!bus.result_valid && lat < 20000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 20) bus.box_valid = 1'b0;
    end
    bus.box_valid = 1'b0;
    chk("latency", lat, bad ? 2 : (sr == 0 ? 3 : n + 4));
    chk("status", statuses(), st);
    chk("box_err", bus.box_err, bad);
`ifdef FINGER_ZONE_COUNT_EN
    chk("zone_count", bus.zone_count, zc);
`endif
    chk("reads", rd_n - rd0, n);
    if (n > 0) begin
      chk("first_addr", rdq[rd0], first);
      chk("last_addr", rdq[rd_n-1], last);
      chk("addr_sum", rd_sum - sum0, sum);
    end
    @(negedge clk);
    chk("rv_pulse", bus.result_valid, 0);
    chk("rv_count", rv_n - rv0, 1);
  endtask
  initial begin
    int sr, sc, er, ec, w, rv0, kind;
    bus.box_valid = 1'b0;
    drive(0, 0, 0, 0);
    fill(0);
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.box_ready, 0);
    chk("rst_rd_en", bus.mem_rd_en, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rv", bus.result_valid, 0);
    chk("rst_status", statuses(), 0);
    chk("rst_err", bus.box_err, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.box_ready, 1);
    fill(100);
    rv0 = rv_n;
    bus.box_valid = 1'b1;
    drive(40, 30, 70, 80);
    @(negedge clk);
    bus.box_valid = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_rd_en", bus.mem_rd_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rd_en", bus.mem_rd_en, 0);
    chk("async_ready", bus.box_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", bus.box_ready, 1);
    chk("rel_status", statuses(), 0);
    repeat (10) @(negedge clk);
    chk("rel_no_result", rv_n - rv0, 0);
    chk("rel_rd_en", bus.mem_rd_en, 0);
    run_box(30, 30, 70, 69, 1'b1);
    fill(0);
    for (int r = 0; r < 120; r++)
      for (int c = 0; c < 8; c++) begin
        mask[r*160 + 30 + c] = 1'b1;
        mask[r*160 + 54 + c] = 1'b1;
      end
    run_box(30, 30, 70, 69, 1'b0);
    fill(0);
    for (int r = 0; r < 2; r++) begin
      mask[r*160 + 50] = 1'b1;
      mask[r*160 + 53] = 1'b1;
      mask[r*160 + 55] = 1'b1;
      mask[r*160 + 57] = 1'b1;
      mask[r*160 + 59] = 1'b1;
    end
    run_box(3, 50, 20, 60, 1'b0);
    run_box(0, 50, 20, 60, 1'b0);
    run_box(30, 90, 70, 80, 1'b0);
    run_box(70, 30, 60, 80, 1'b0);
    run_box(30, 30, 120, 80, 1'b0);
    run_box(30, 30, 70, 160, 1'b0);
    fill(100);
    run_box(119, 0, 119, 159, 1'b0);
    for (int t = 0; t < 16; t++) begin
      fill($urandom_range(0, 100));
      sr = $urandom_range(0, 119);
      er = $urandom_range(sr, 119);
      w = $urandom_range(5, 48);
      sc = $urandom_range(0, 160 - w);
      ec = sc + w - 1;
      kind = $urandom_range(0, 7);
      if (kind == 0) ec = $urandom_range(160, 255);
      if (kind == 1) er = $urandom_range(120, 255);
      run_box(sr, sc, er, ec, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
